pcm_mem_arbiter: RTL
====================

PCM_MEM_ARBITER -- requirements
Module: pcm_mem_arbiter

Interface
REQ-001 SHALL have parameter HOST_STARVE_LIMIT, default 64, meaning host-wait cycles before host is forced ahead of A/B (range 1..255).
REQ-002 SHALL have port clk  in  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports a_valid in 1, a_addr in 24, a_ready out 1, a_rdata out 8: ADPCM-A reader request port.
REQ-005 SHALL have ports b_valid in 1, b_addr in 24, b_ready out 1, b_rdata out 8: ADPCM-B reader request port.
REQ-006 SHALL have ports h_valid in 1, h_addr in 24, h_ready out 1, h_rdata out 8: host/debug request port.
REQ-007 SHALL have ports mem_valid out 1, mem_addr out 24, mem_ready in 1, mem_rdata in 8: shared PCM memory port.
REQ-008 SHALL have port owner  out  2  current grant (0 none, 1 A, 2 B, 3 host).
REQ-009 SHALL have ports max_wait_a out 8, max_wait_b out 8, stats_clear in 1: worst-case wait statistics.

Function
REQ-010 SHALL implement FSM states IDLE and BUSY.
REQ-011 In IDLE with any valid high, SHALL select a winner, latch its index into owner and its address into an address register, and enter BUSY next cycle.
REQ-012 Priority: host wins if host starve counter equals HOST_STARVE_LIMIT; else A/B round-robin via last-served bit (the one not served last wins when both are valid); else host if only host is valid.
REQ-013 In BUSY: mem_valid SHALL be 1 and mem_addr SHALL equal the latched address, both held stable until mem_ready.
REQ-014 On mem_ready in BUSY: owner's x_ready SHALL be 1 that same cycle (combinational), x_rdata = mem_rdata; FSM returns to IDLE; owner cleared to 0; last-served bit updated if owner was A or B.
REQ-015 Non-owner x_ready SHALL be 0 always; x_rdata is don't-care unless x_ready=1.
REQ-016 mem_ready outside BUSY SHALL be ignored.
REQ-017 Minimum transaction latency SHALL be 2 cycles (IDLE select -> BUSY with mem_ready same cycle); at least one IDLE cycle SHALL occur between grants.
REQ-018 Requesters hold valid/addr until ready; if owner drops valid while BUSY, transaction SHALL still complete on mem_ready, with x_ready pulsing only if owner's valid is still high.
REQ-019 Host starve counter: increments (saturating at HOST_STARVE_LIMIT) each cycle h_valid=1 and owner!=3; cleared when host is granted or h_valid=0.
REQ-020 Wait counters (A, B): 8-bit, increment saturating at 255 each cycle x_valid=1 and x_ready=0; cleared on the cycle after x_ready=1 or while x_valid=0.
REQ-021 On x_ready=1, max_wait_x SHALL update to max(max_wait_x, wait_x+1), saturating at 255.
REQ-022 stats_clear SHALL zero max_wait_a/b next cycle; coincident update is discarded.

Reset
REQ-023 Reset SHALL force IDLE, owner=0, mem_valid=0, all x_ready=0, last-served=B (A wins first tie), host starve counter=0, wait counters=0, max_wait_a/b=0.
REQ-024 Reset mid-BUSY SHALL abandon the transaction: mem_valid=0 the cycle after reset is sampled; a later mem_ready is ignored.

Verification
REQ-025 a_valid alone, addr 0x012345, mem_ready 3 cycles after mem_valid -> mem_addr=0x012345, a_ready 1 cycle with a_rdata=mem_rdata, owner 1->0, max_wait_a=5.
REQ-026 a_valid and b_valid held continuously, mem_ready immediate -> grants alternate A,B,A,B; host never granted while h_valid=0.
REQ-027 a_valid, b_valid continuously high, h_valid high, HOST_STARVE_LIMIT=4 -> host granted once starve counter reaches 4, then A/B alternation resumes.
REQ-028 Reset asserted while BUSY for B with mem_ready withheld, then mem_ready pulsed -> mem_valid=0, b_ready stays 0, owner=0.
REQ-029 B wait of 10 cycles then stats_clear, then B wait of 3 cycles -> max_wait_b reads 10, then 0, then 3.
REQ-030 a_valid dropped mid-BUSY -> mem_valid held until mem_ready, a_ready stays 0, FSM returns to IDLE.

Source files
------------

// File: rtl/pcm_mem_arbiter.sv
// Three-way arbiter (ADPCM-A, ADPCM-B, host) onto one PCM memory port.
// One grant at a time, A/B round-robin, host forced ahead after a starvation limit.
module pcm_mem_arbiter #(
  parameter int unsigned HOST_STARVE_LIMIT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [23:0] a_addr,
  output logic        a_ready,
  output logic [7:0]  a_rdata,
  input  logic        b_valid,
  input  logic [23:0] b_addr,
  output logic        b_ready,
  output logic [7:0]  b_rdata,
  input  logic        h_valid,
  input  logic [23:0] h_addr,
  output logic        h_ready,
  output logic [7:0]  h_rdata,
  output logic        mem_valid,
  output logic [23:0] mem_addr,
  input  logic        mem_ready,
  input  logic [7:0]  mem_rdata,
  output logic [1:0]  owner,
  output logic [7:0]  max_wait_a,
  output logic [7:0]  max_wait_b,
  input  logic        stats_clear
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [7:0] STARVE_LIMIT = 8'(HOST_STARVE_LIMIT);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_A    = 2'd1;
  localparam logic [1:0] OWN_B    = 2'd2;
  localparam logic [1:0] OWN_H    = 2'd3;

  state_t      state_q;
  logic [1:0]  owner_q;
  logic [23:0] addr_q;
  logic        last_b_q;
  logic [7:0]  starve_q, starve_d;
  logic [7:0]  wait_a_q, wait_a_d;
  logic [7:0]  wait_b_q, wait_b_d;
  logic [7:0]  max_a_q, max_a_d;
  logic [7:0]  max_b_q, max_b_d;
  logic [7:0]  cand_a, cand_b;
  logic [1:0]  sel;
  logic        done;

  // Starved host outranks everything; otherwise A/B alternate on ties.
  always_comb begin
    sel = OWN_NONE;
    if (h_valid && (starve_q == STARVE_LIMIT)) sel = OWN_H;
    else if (a_valid && b_valid)               sel = last_b_q ? OWN_A : OWN_B;
    else if (a_valid)                          sel = OWN_A;
    else if (b_valid)                          sel = OWN_B;
    else if (h_valid)                          sel = OWN_H;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_NONE;
      addr_q   <= 24'd0;
      last_b_q <= 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (sel != OWN_NONE) begin
            state_q <= S_BUSY;
            owner_q <= sel;
            case (sel)
              OWN_A:   addr_q <= a_addr;
              OWN_B:   addr_q <= b_addr;
              default: addr_q <= h_addr;
            endcase
          end
        end
        S_BUSY: begin
          if (mem_ready) begin
            state_q <= S_IDLE;
            owner_q <= OWN_NONE;
            if (owner_q == OWN_A) last_b_q <= 1'b0;
            if (owner_q == OWN_B) last_b_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign done      = (state_q == S_BUSY) && mem_ready;
  assign mem_valid = (state_q == S_BUSY);
  assign mem_addr  = addr_q;
  assign owner     = owner_q;

  // A requester that withdrew mid-transaction gets no ready pulse.
  assign a_ready = done && (owner_q == OWN_A) && a_valid;
  assign b_ready = done && (owner_q == OWN_B) && b_valid;
  assign h_ready = done && (owner_q == OWN_H) && h_valid;
  assign a_rdata = mem_rdata;
  assign b_rdata = mem_rdata;
  assign h_rdata = mem_rdata;

  assign cand_a = (wait_a_q == 8'hFF) ? 8'hFF : wait_a_q + 8'd1;
  assign cand_b = (wait_b_q == 8'hFF) ? 8'hFF : wait_b_q + 8'd1;

  always_comb begin
    starve_d = starve_q;
    if (!h_valid || ((state_q == S_IDLE) && (sel == OWN_H))) starve_d = 8'd0;
    else if ((owner_q != OWN_H) && (starve_q < STARVE_LIMIT)) starve_d = starve_q + 8'd1;

    wait_a_d = (!a_valid || a_ready) ? 8'd0 : cand_a;
    wait_b_d = (!b_valid || b_ready) ? 8'd0 : cand_b;

    max_a_d = max_a_q;
    max_b_d = max_b_q;
    if (stats_clear) begin
      max_a_d = 8'd0;
      max_b_d = 8'd0;
    end else begin
      if (a_ready && (cand_a > max_a_q)) max_a_d = cand_a;
      if (b_ready && (cand_b > max_b_q)) max_b_d = cand_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= 8'd0;
      wait_a_q <= 8'd0;
      wait_b_q <= 8'd0;
      max_a_q  <= 8'd0;
      max_b_q  <= 8'd0;
    end else begin
      starve_q <= starve_d;
      wait_a_q <= wait_a_d;
      wait_b_q <= wait_b_d;
      max_a_q  <= max_a_d;
      max_b_q  <= max_b_d;
    end
  end

  assign max_wait_a = max_a_q;
  assign max_wait_b = max_b_q;

endmodule
